// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache between the MEM stage and main memory.
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dcache_ctrl #(
    parameter int unsigned INDEX_BITS  = 3,
    parameter int unsigned MEM_LAT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        err
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam int unsigned Lines   = 1 << INDEX_BITS;
    localparam int unsigned TagBits = 16 - 2 - INDEX_BITS;
    localparam int unsigned CntW    = $clog2(MEM_LAT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StWb, StFill} state_e;

    state_e                   state_q;
    logic [Lines-1:0]         valid_q;
    logic [Lines-1:0]         dirty_q;
    logic [TagBits-1:0]       tag_q  [Lines];
    logic [63:0]              data_q [Lines];
    logic [CntW-1:0]          cnt_q;
    logic                     abort_q;
    logic                     err_q;

    logic [INDEX_BITS-1:0]    idx;
    logic [1:0]               off;
    logic [TagBits-1:0]       tag;
    logic                     req;
    logic                     hit;
    logic                     in_idle;
    logic                     hit_ok;
    logic                     miss_start;
    logic                     store_hit;
    logic                     fill_done;
    logic                     timeout;
    logic [15:0]              hit_word;

    always_comb begin
        idx        = cpu_addr[2 +: INDEX_BITS];
        off        = cpu_addr[1:0];
        tag        = cpu_addr[15 -: TagBits];
        req        = cpu_re | cpu_we;
        hit        = valid_q[idx] & (tag_q[idx] == tag) & req;
        in_idle    = (state_q == StIdle);
        // The cycle after a watchdog abort releases the pipeline without serving it.
        hit_ok     = in_idle & ~abort_q & hit;
        miss_start = in_idle & ~abort_q & req & ~hit;
        store_hit  = hit_ok & cpu_we;
        fill_done  = (state_q == StFill) & mem_rdy;
        timeout    = ~in_idle & ~mem_rdy & (cnt_q == CntW'(MEM_LAT_MAX - 1));
        hit_word   = data_q[idx][{off, 4'b0000} +: 16];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    abort_q <= 1'b0;
                    cnt_q   <= '0;
                    if (miss_start) begin
                        state_q <= (valid_q[idx] & dirty_q[idx]) ? StWb : StFill;
                    end
                    if (store_hit) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                StWb: begin
                    if (mem_rdy) begin
                        dirty_q[idx] <= 1'b0;
                        state_q      <= StFill;
                        cnt_q        <= '0;
                    end else if (timeout) begin
                        valid_q[idx] <= 1'b0;
                        dirty_q[idx] <= 1'b0;
                        err_q        <= 1'b1;
                        abort_q      <= 1'b1;
                        state_q      <= StIdle;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StFill: begin
                    if (mem_rdy) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= StIdle;
                        cnt_q        <= '0;
                    end else if (timeout) begin
                        valid_q[idx] <= 1'b0;
                        err_q        <= 1'b1;
                        abort_q      <= 1'b1;
                        state_q      <= StIdle;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag and data arrays are not reset; valid_q guards their contents.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[idx] <= mem_rdata;
            tag_q[idx]  <= tag;
        end else if (store_hit) begin
            data_q[idx][{off, 4'b0000} +: 16] <= cpu_wdata;
        end
    end

    always_comb begin
        // Gating with rst_n drops the stall at once even if a request is still presented.
        cpu_stall = rst_n & (~in_idle | miss_start);
        cpu_rdata = hit_ok ? hit_word : 16'h0000;
        mem_re    = (state_q == StFill);
        mem_we    = (state_q == StWb);
        mem_addr  = 16'h0000;
        mem_wdata = 64'h0;
        if (state_q == StWb) begin
            mem_addr  = {tag_q[idx], idx, 2'b00};
            mem_wdata = data_q[idx];
        end else if (state_q == StFill) begin
            mem_addr = {cpu_addr[15:2], 2'b00};
        end
        err = err_q;
    end

`ifdef DCACHE_STATS_EN
    logic        missed_q;
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    // missed_q marks a request that already took a miss, so its final hit is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missed_q   <= 1'b0;
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else begin
            if (miss_start) begin
                missed_q <= 1'b1;
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_q <= miss_cnt_q + 16'h0001;
                end
            end else if (hit_ok) begin
                missed_q <= 1'b0;
                if (!missed_q && hit_cnt_q != 16'hFFFF) begin
                    hit_cnt_q <= hit_cnt_q + 16'h0001;
                end
            end else if (in_idle && abort_q) begin
                missed_q <= 1'b0;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a latency-programmable memory responder.
module tb_dcache_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_re;
    logic        cpu_we;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_rdy;
    logic        err;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    dcache_ctrl #(
        .INDEX_BITS (3),
        .MEM_LAT_MAX(255)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_addr (cpu_addr),
        .cpu_re   (cpu_re),
        .cpu_we   (cpu_we),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rdy  (mem_rdy),
        .err      (err)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int tests;
    int fails;

    int wb_lat;
    int fill_lat;
    bit mem_hang;
    int mcnt;
    logic [63:0] mem_model [logic [15:0]];

    // Trace of the most recent access
    int          stall_cycles;
    logic [15:0] got_rdata;
    bit          saw_re, saw_we, we_first, saw_both;
    logic [15:0] re_addr, we_addr;
    logic [63:0] we_wdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: pulses mem_rdy on the N-th cycle of a request.
    initial begin
        mem_rdy   = 1'b0;
        mem_rdata = 64'h0;
        mcnt      = 0;
        forever begin
            @(negedge clk);
            #2;
            mem_rdy = 1'b0;
            if (!rst_n || !(mem_re || mem_we)) begin
                mcnt = 0;
            end else if (!mem_hang) begin
                mcnt++;
                if (mem_we && mcnt == wb_lat) begin
                    mem_model[mem_addr] = mem_wdata;
                    mem_rdy = 1'b1;
                    mcnt = 0;
                end else if (mem_re && mcnt == fill_lat) begin
                    mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 64'h0;
                    mem_rdy = 1'b1;
                    mcnt = 0;
                end
            end
        end
    end

    task automatic do_access(input logic re, input logic we, input logic [15:0] addr,
                             input logic [15:0] wdata);
        @(negedge clk);
        cpu_re    = re;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        #1;
        stall_cycles = 0;
        saw_re = 0; saw_we = 0; we_first = 0; saw_both = 0;
        re_addr = 16'h0; we_addr = 16'h0; we_wdata = 64'h0;
        while (cpu_stall && stall_cycles < 1000) begin
            if (mem_re && mem_we) saw_both = 1;
            if (mem_we && !saw_we) begin
                saw_we = 1; we_addr = mem_addr; we_wdata = mem_wdata;
                if (!saw_re) we_first = 1;
            end
            if (mem_re && !saw_re) begin
                saw_re = 1; re_addr = mem_addr;
            end
            stall_cycles++;
            @(negedge clk);
            #1;
        end
        got_rdata = cpu_rdata;
        if (mem_re || mem_we) saw_both = 1;
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if (cpu_stall !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: stall=%b re=%b we=%b, required 0 0 0",
                     cpu_stall, mem_re, mem_we);
        end
        tests++;
        if (err !== 1'b0 || cpu_rdata !== 16'h0 || mem_addr !== 16'h0) begin
            fails++;
            $display("FAIL reset_data: err=%b rdata=%h maddr=%h, required 0 0000 0000",
                     err, cpu_rdata, mem_addr);
        end
    endtask

    task automatic test_load_miss;
        fill_lat = 5;
        do_access(1'b1, 1'b0, 16'h0010, 16'h0);
        tests++;
        if (stall_cycles !== 6) begin
            fails++;
            $display("FAIL load_miss_stall: got %0d, required 6", stall_cycles);
        end
        tests++;
        if (got_rdata !== 16'hBEEF) begin
            fails++;
            $display("FAIL load_miss_rdata: got %h, required beef", got_rdata);
        end
        tests++;
        if (!saw_re || re_addr !== 16'h0010 || saw_we || saw_both) begin
            fails++;
            $display("FAIL load_miss_mem: re=%b addr=%h we=%b both=%b, required 1 0010 0 0",
                     saw_re, re_addr, saw_we, saw_both);
        end
    endtask

    task automatic test_store_hit;
        do_access(1'b0, 1'b1, 16'h0011, 16'h1234);
        tests++;
        if (stall_cycles !== 0 || saw_re || saw_we) begin
            fails++;
            $display("FAIL store_hit: stall=%0d re=%b we=%b, required 0 0 0",
                     stall_cycles, saw_re, saw_we);
        end
        do_access(1'b1, 1'b0, 16'h0011, 16'h0);
        tests++;
        if (stall_cycles !== 0 || got_rdata !== 16'h1234) begin
            fails++;
            $display("FAIL load_after_store: stall=%0d rdata=%h, required 0 1234",
                     stall_cycles, got_rdata);
        end
    endtask

    task automatic test_dirty_miss;
        wb_lat   = 3;
        fill_lat = 4;
        do_access(1'b1, 1'b0, 16'h0110, 16'h0);
        tests++;
        if (!saw_we || !we_first || we_addr !== 16'h0010) begin
            fails++;
            $display("FAIL wb_addr: we=%b first=%b addr=%h, required 1 1 0010",
                     saw_we, we_first, we_addr);
        end
        tests++;
        if (we_wdata[31:16] !== 16'h1234 || we_wdata[15:0] !== 16'hBEEF) begin
            fails++;
            $display("FAIL wb_data: got %h, required word1 1234 word0 beef", we_wdata);
        end
        tests++;
        if (!saw_re || re_addr !== 16'h0110 || saw_both) begin
            fails++;
            $display("FAIL dirty_fill: re=%b addr=%h both=%b, required 1 0110 0",
                     saw_re, re_addr, saw_both);
        end
        tests++;
        if (stall_cycles !== 8 || got_rdata !== 16'hCAFE) begin
            fails++;
            $display("FAIL dirty_miss_result: stall=%0d rdata=%h, required 8 cafe",
                     stall_cycles, got_rdata);
        end
    endtask

    task automatic test_read_write_same;
        fill_lat = 2;
        do_access(1'b1, 1'b0, 16'h0012, 16'h0);
        tests++;
        if (stall_cycles !== 3 || got_rdata !== 16'h00AA || saw_we) begin
            fails++;
            $display("FAIL refetch: stall=%0d rdata=%h we=%b, required 3 00aa 0",
                     stall_cycles, got_rdata, saw_we);
        end
        do_access(1'b1, 1'b1, 16'h0012, 16'h5555);
        tests++;
        if (stall_cycles !== 0 || got_rdata !== 16'h00AA) begin
            fails++;
            $display("FAIL rw_old_value: stall=%0d rdata=%h, required 0 00aa",
                     stall_cycles, got_rdata);
        end
        do_access(1'b1, 1'b0, 16'h0012, 16'h0);
        tests++;
        if (got_rdata !== 16'h5555) begin
            fails++;
            $display("FAIL rw_new_value: got %h, required 5555", got_rdata);
        end
        do_access(1'b1, 1'b0, 16'h0011, 16'h0);
        tests++;
        if (stall_cycles !== 0 || got_rdata !== 16'h1234) begin
            fails++;
            $display("FAIL wb_roundtrip: stall=%0d rdata=%h, required 0 1234",
                     stall_cycles, got_rdata);
        end
    endtask

    task automatic test_reset_mid_fill;
        mem_hang = 1;
        @(negedge clk);
        cpu_re   = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0020;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (mem_re !== 1'b1 || cpu_stall !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_fill: re=%b stall=%b, required 1 1", mem_re, cpu_stall);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
            fails++;
            $display("FAIL async_abort: re=%b we=%b stall=%b, required 0 0 0",
                     mem_re, mem_we, cpu_stall);
        end
        @(negedge clk);
        cpu_re   = 1'b0;
        rst_n    = 1'b1;
        mem_hang = 0;
        fill_lat = 3;
        do_access(1'b1, 1'b0, 16'h0010, 16'h0);
        tests++;
        if (stall_cycles !== 4 || !saw_re || saw_we || got_rdata !== 16'hBEEF) begin
            fails++;
            $display("FAIL post_reset_miss: stall=%0d re=%b we=%b rdata=%h, required 4 1 0 beef",
                     stall_cycles, saw_re, saw_we, got_rdata);
        end
    endtask

    task automatic test_watchdog;
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_before: got %b, required 0", err);
        end
        mem_hang = 1;
        do_access(1'b1, 1'b0, 16'h0014, 16'h0);
        tests++;
        if (stall_cycles !== 256 || got_rdata !== 16'h0000) begin
            fails++;
            $display("FAIL timeout_release: stall=%0d rdata=%h, required 256 0000",
                     stall_cycles, got_rdata);
        end
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_err: got %b, required 1", err);
        end
        mem_hang = 0;
        fill_lat = 2;
        do_access(1'b1, 1'b0, 16'h0014, 16'h0);
        tests++;
        if (stall_cycles !== 3 || !saw_re || got_rdata !== 16'h7777 || err !== 1'b1) begin
            fails++;
            $display("FAIL after_timeout: stall=%0d re=%b rdata=%h err=%b, required 3 1 7777 1",
                     stall_cycles, saw_re, got_rdata, err);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        wb_lat    = 1;
        fill_lat  = 1;
        mem_hang  = 0;
        cpu_addr  = 16'h0;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_wdata = 16'h0;
        mem_model[16'h0010] = {16'h0000, 16'h00AA, 16'h0000, 16'hBEEF};
        mem_model[16'h0110] = {16'h0004, 16'h0003, 16'h0002, 16'hCAFE};
        mem_model[16'h0014] = {16'h0000, 16'h0000, 16'h0000, 16'h7777};
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_load_miss;
        test_store_hit;
        test_dirty_miss;
        test_read_write_same;
        test_reset_mid_fill;
        test_watchdog;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the pipeline MEM stage and the multi-cycle unified main memory.
- Serves single-cycle load/store hits.
- On a miss it asserts a stall to the pipeline, writes back a dirty victim block, then fills the line from memory.
- Responder to the MEM stage's memRd/memWr requests; initiator toward main memory.

Parameters:
- INDEX_BITS, 3, log2 of line count (default 8 lines).
- MEM_LAT_MAX, 255, watchdog limit in cycles for an outstanding memory request (width of the internal wait counter).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset.
- cpu_addr  in  16  word address from MEM stage (ALU result).
- cpu_re  in  1  load request.
- cpu_we  in  1  store request.
- cpu_wdata  in  16  store data.
- cpu_rdata  out  16  load data; valid when cpu_re & ~cpu_stall.
- cpu_stall  out  1  freeze pipeline; request not yet complete.
- mem_addr  out  16  block address to memory; low 2 bits always 0.
- mem_re  out  1  block read request.
- mem_we  out  1  block write request.
- mem_wdata  out  64  victim block, word0 in [15:0].
- mem_rdata  in  64  fill block, word0 in [15:0].
- mem_rdy  in  1  one-cycle completion pulse for the current request.
- err  out  1  sticky watchdog timeout flag.

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Address split: offset = addr[1:0] (4 words per line); index = addr[2+INDEX_BITS-1:2]; tag = addr[15:2+INDEX_BITS] (11 bits at default).
- Per line: valid bit, dirty bit, tag, 64-bit data. Valid and dirty clear on reset; tag and data are not reset.
- hit = valid[index] & (tag match) & (cpu_re | cpu_we).
- Reset values: state IDLE, all outputs 0, err 0, wait counter 0.
- FSM states: IDLE, WB (writeback), FILL.
- IDLE, no request: cpu_stall 0, no memory activity.
- IDLE, hit: cpu_stall 0.
  - Load: cpu_rdata = selected word, combinational, same cycle.
  - Store: the word is written at the clock edge and dirty is set.
- IDLE, miss: cpu_stall 1 combinationally in the same cycle.
  - Victim valid & dirty: go to WB.
  - Otherwise: go to FILL.
- WB:
  - mem_we = 1, mem_addr = {victim tag, index, 2'b00}, mem_wdata = line data.
  - Held stable until mem_rdy is sampled high; then clear dirty and go to FILL.
- FILL:
  - mem_re = 1, mem_addr = {cpu_addr[15:2], 2'b00}.
  - On mem_rdy: load mem_rdata, set tag, valid = 1, dirty = 0; go to IDLE.
- After returning to IDLE, the still-held request hits and completes that cycle. cpu_stall stays 1 through WB and FILL and drops only on the hit cycle.
  - Load miss (clean victim): fill latency + 1 cycles.
  - Dirty miss: writeback latency + fill latency + 1 cycles.
- mem_re and mem_we are never asserted together. mem_rdy is ignored in IDLE.
- cpu_re and cpu_we both high: treated as a store. cpu_rdata still shows the pre-write word.
- cpu_addr, cpu_re, cpu_we and cpu_wdata must stay stable while cpu_stall = 1. The pipeline guarantees this by freezing; the design does not check it.
- Watchdog: the counter runs in WB/FILL and clears on a state change. When it reaches MEM_LAT_MAX:
  - err is set (sticky until reset);
  - the FSM returns to IDLE;
  - valid is cleared for the affected line;
  - cpu_stall is released for one cycle with cpu_rdata = 16'h0000.
- Reset mid-operation: asynchronous abort. State goes to IDLE; mem_re, mem_we and cpu_stall drop immediately; all valid and dirty bits are cleared.
- Store-hit and fill are never in the same cycle, so the data array has a single write port.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined:
  - Adds 16-bit outputs hit_cnt and miss_cnt, both saturating at 16'hFFFF and reset to 0.
  - hit_cnt increments on each IDLE hit that was not preceded by a miss for the same request.
  - miss_cnt increments on each IDLE→WB/FILL transition.
- When undefined: the ports and counters are absent, with no other behavioural change.

Test Plan:
- Reset, then load 0x0010 with memory returning word0 = 16'hBEEF after 5 cycles → mem_re high with mem_addr 0x0010; stall for 6 cycles; cpu_rdata = 16'hBEEF; no mem_we.
- Store 16'h1234 to 0x0011 after the fill above → cpu_stall 0, no memory traffic; a following load of 0x0011 returns 16'h1234 in the same cycle.
- Load 0x0110 (same index 4, different tag) after the dirty store → mem_we first with mem_addr 0x0010 and mem_wdata[31:16] = 16'h1234; then mem_re with mem_addr 0x0110; stall = WB latency + fill latency + 1.
- Simultaneous cpu_re = cpu_we = 1 at 0x0012 (hit, old value 16'h00AA, wdata 16'h5555) → cpu_rdata 16'h00AA that cycle; a later load returns 16'h5555.
- Assert rst_n = 0 during FILL → mem_re and cpu_stall drop without waiting for a clock; after reset, a load of 0x0010 misses again.
- Hold mem_rdy low for MEM_LAT_MAX cycles in FILL → err = 1; stall released with cpu_rdata 0; the next access to that line misses.
